acl_spi_arbiter: RTL and testbench
==================================

# acl_spi_arbiter

Shares the single accelerometer SPI transmitter (ready/inst/rdh_wrl/reg_addr/dout in, CSN/din/din_valid out) between N_REQ independent requesters, e.g. the register configuration sequencer, the periodic axis sampler and the interrupt-status reader. It arbitrates round-robin and issues one single-byte ADXL362 read or write per grant. It tracks each transaction from its CSN low/high edges, returns read data or an error to the winning requester, and enforces a minimum CSN-high gap between transactions.

## Interface
Parameters:
- N_REQ, 3: number of requesters (2..8).
- GAP_CYCLES, 16: minimum clk cycles spent in GAP after each transaction.
- START_TIMEOUT, 64: max cycles from spi_ready pulse to CSN falling.
- DONE_TIMEOUT, 4096: max cycles with CSN low.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  N_REQ  per-requester request; held until its req_grant pulse.
- req_rd  in  N_REQ  1 = read, 0 = write.
- req_addr  in  8*N_REQ  register address, requester i at [8i+7:8i].
- req_wdata  in  8*N_REQ  write data, same packing.
- req_grant  out  N_REQ  one-cycle accept pulse, one-hot.
- rsp_valid  out  N_REQ  one-cycle completion pulse to the granted requester.
- rsp_rdata  out  8  read data, valid with rsp_valid.
- rsp_err  out  1  error flag, valid with rsp_valid.
- busy  out  1  high from grant until GAP ends.
- err_cnt  out  8  saturating count of errored transactions.
- spi_ready  out  1  one-cycle start pulse to the transmitter.
- spi_inst  out  8  0x0B read, 0x0A write.
- spi_rdh_wrl  out  1  1 = read, 0 = write.
- spi_reg_addr  out  8  register address.
- spi_dout  out  8  write data; 0x00 on reads.
- spi_csn  in  1  transmitter CSN, low while the transaction is active.
- spi_din  in  8  received byte.
- spi_din_valid  in  1  received-byte strobe.

## Operation
- States: IDLE, WAIT_START, WAIT_DONE, GAP.
- IDLE: if any req_valid is set, pick winner k by round-robin starting at last+1 mod N_REQ.
  - Register {rd, addr, wdata} of k.
  - Next cycle: req_grant[k]=1, spi_ready=1, spi_* fields driven; last<=k; go to WAIT_START.
- WAIT_START: spi_ready=0.
  - spi_csn sampled 0 -> WAIT_DONE.
  - START_TIMEOUT cycles elapse without CSN low -> error completion, go to GAP.
- WAIT_DONE: spi_din_valid captures spi_din into the data register and sets got_data.
  - spi_csn sampled 1 -> completion.
  - DONE_TIMEOUT cycles elapse -> error completion.
- Completion: rsp_valid[k]=1 for one cycle and go to GAP. rsp_err=1 when:
  - either timeout fired, or
  - a read completed with got_data=0; rsp_rdata=0x00 in this case.
  - A write always returns rsp_rdata=0x00.
- Every error increments err_cnt, which saturates at 0xFF.
- GAP: count GAP_CYCLES cycles, then IDLE. Requests arriving in GAP wait; no grant is issued in GAP.
- spi_inst/spi_rdh_wrl/spi_reg_addr/spi_dout hold their values from the grant until the next grant.
- A spi_din_valid pulse outside WAIT_DONE is ignored.
- A requester that deasserts req_valid before its grant is simply not served. This is legal.

## Timing
- Reset values: all outputs 0, except spi_rdh_wrl=1 and spi_inst=0x0B. State IDLE, last=N_REQ-1 (requester 0 wins first), counters 0, got_data 0.
- Grant latency: req_valid seen in IDLE at cycle t -> req_grant and spi_ready high at t+1. From reset release, first grant no earlier than the second clk edge.
- Response: spi_csn sampled high at cycle c in WAIT_DONE -> rsp_valid at c+1.
- Back-to-back: next grant no earlier than GAP_CYCLES+1 cycles after rsp_valid.
- spi_csn and spi_din_valid are synchronous to clk; no resynchronisation.
- Simultaneous requests: exactly one grant. A continuously requesting source waits at most N_REQ-1 other transactions.
- Reset mid-transaction: everything returns to reset values immediately; no rsp_valid is issued for the aborted transaction. The transmitter is reset by the same rst.

## Test plan
- Write: req 0 wr addr 0x2D data 0x0A -> grant[0] plus spi_ready at t+1 with inst 0x0A, rdh_wrl 0, dout 0x0A; CSN low then high -> rsp_valid[0], rsp_err 0, rsp_rdata 0x00.
- Read: req 1 rd addr 0x09; transmitter model returns din 0x5A -> inst 0x0B, rsp_valid[1], rsp_rdata 0x5A, err 0.
- Arbitration: all three requesters hold req_valid -> grant order 0,1,2,0; at least GAP_CYCLES cycles of busy GAP between each rsp_valid and the next grant.
- Start timeout: spi_csn stuck high -> rsp_valid after START_TIMEOUT cycles, rsp_err 1, err_cnt 1.
- Read with no din_valid before CSN rises -> rsp_err 1, rsp_rdata 0x00.
- rst pulse during WAIT_DONE -> all outputs at reset values, no rsp_valid; pending req 0 is granted after release.

Source files
------------

// File: rtl/acl_spi_arbiter.sv
// Round-robin arbiter sharing one ADXL362 SPI transmitter between N_REQ requesters.
// Grant one cycle after request in IDLE; response one cycle after CSN rises; requests wait (held) through busy/GAP.
module acl_spi_arbiter #(
  parameter int N_REQ         = 3,
  parameter int GAP_CYCLES    = 16,
  parameter int START_TIMEOUT = 64,
  parameter int DONE_TIMEOUT  = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ-1:0]   req_rd,
  input  logic [8*N_REQ-1:0] req_addr,
  input  logic [8*N_REQ-1:0] req_wdata,
  output logic [N_REQ-1:0]   req_grant,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [7:0]         rsp_rdata,
  output logic               rsp_err,
  output logic               busy,
  output logic [7:0]         err_cnt,
  output logic               spi_ready,
  output logic [7:0]         spi_inst,
  output logic               spi_rdh_wrl,
  output logic [7:0]         spi_reg_addr,
  output logic [7:0]         spi_dout,
  input  logic               spi_csn,
  input  logic [7:0]         spi_din,
  input  logic               spi_din_valid
);

  localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int MAXA = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
  localparam int MAXC = (DONE_TIMEOUT > MAXA) ? DONE_TIMEOUT : MAXA;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [7:0] INST_RD = 8'h0B;
  localparam logic [7:0] INST_WR = 8'h0A;

  typedef enum logic [1:0] {IDLE, WAIT_START, WAIT_DONE, GAP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   last;
  logic [7:0]      data_r;
  logic            got_data;

  logic            found;
  logic [IW-1:0]   win;
  logic [IW-1:0]   cand;
  logic            do_grant;
  logic            do_done;
  logic            done_err;
  logic            cnt_clr;
  logic            got_eff;
  logic [7:0]      data_eff;
  logic [7:0]      done_rdata;

  logic [7:0] addr_a  [N_REQ];
  logic [7:0] wdata_a [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign addr_a[i]  = req_addr[8*i +: 8];
    assign wdata_a[i] = req_wdata[8*i +: 8];
  end

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand = IW'((int'(last) + off) % N_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // A byte arriving in the same cycle CSN rises still counts for this read.
  assign got_eff  = got_data | spi_din_valid;
  assign data_eff = spi_din_valid ? spi_din : data_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    do_done   = 1'b0;
    done_err  = 1'b0;
    cnt_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          do_grant  = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = WAIT_START;
        end
      end
      WAIT_START: begin
        if (!spi_csn) begin
          cnt_clr   = 1'b1;
          state_nxt = WAIT_DONE;
        end else if (cnt == CW'(START_TIMEOUT - 1)) begin
          do_done   = 1'b1;
          done_err  = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = GAP;
        end
      end
      WAIT_DONE: begin
        if (spi_csn) begin
          do_done   = 1'b1;
          done_err  = spi_rdh_wrl & ~got_eff;
          cnt_clr   = 1'b1;
          state_nxt = GAP;
        end else if (cnt == CW'(DONE_TIMEOUT - 1)) begin
          do_done   = 1'b1;
          done_err  = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (cnt == CW'(GAP_CYCLES - 1)) begin
          cnt_clr   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign done_rdata = (spi_rdh_wrl && !done_err) ? data_eff : 8'h00;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      last         <= IW'(N_REQ - 1);
      data_r       <= 8'h00;
      got_data     <= 1'b0;
      req_grant    <= '0;
      rsp_valid    <= '0;
      rsp_rdata    <= 8'h00;
      rsp_err      <= 1'b0;
      err_cnt      <= 8'h00;
      spi_ready    <= 1'b0;
      spi_inst     <= INST_RD;
      spi_rdh_wrl  <= 1'b1;
      spi_reg_addr <= 8'h00;
      spi_dout     <= 8'h00;
    end else begin
      if (cnt_clr || state == IDLE) cnt <= '0;
      else                          cnt <= cnt + 1'b1;

      req_grant <= do_grant ? (N_REQ'(1) << win) : '0;
      spi_ready <= do_grant;

      // spi_* fields double as the in-flight transaction record until the next grant.
      if (do_grant) begin
        last         <= win;
        got_data     <= 1'b0;
        data_r       <= 8'h00;
        spi_rdh_wrl  <= req_rd[win];
        spi_inst     <= req_rd[win] ? INST_RD : INST_WR;
        spi_reg_addr <= addr_a[win];
        spi_dout     <= req_rd[win] ? 8'h00 : wdata_a[win];
      end else if (state == WAIT_DONE && spi_din_valid) begin
        data_r   <= spi_din;
        got_data <= 1'b1;
      end

      rsp_valid <= do_done ? (N_REQ'(1) << last) : '0;
      rsp_err   <= do_done & done_err;
      rsp_rdata <= do_done ? done_rdata : 8'h00;

      if (do_done && done_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_acl_spi_arbiter.sv
// Directed bench for acl_spi_arbiter: bench-driven transmitter, hand-computed expectations.
module tb_acl_spi_arbiter;

  localparam int N     = 3;
  localparam int GAP   = 16;
  localparam int START = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_rd = '0;
  logic [8*N-1:0] req_addr = '0;
  logic [8*N-1:0] req_wdata = '0;
  logic [N-1:0]  req_grant;
  logic [N-1:0]  rsp_valid;
  logic [7:0]    rsp_rdata;
  logic          rsp_err;
  logic          busy;
  logic [7:0]    err_cnt;
  logic          spi_ready;
  logic [7:0]    spi_inst;
  logic          spi_rdh_wrl;
  logic [7:0]    spi_reg_addr;
  logic [7:0]    spi_dout;
  logic          spi_csn = 1'b1;
  logic [7:0]    spi_din = 8'h00;
  logic          spi_din_valid = 1'b0;

  int checks = 0;
  int errors = 0;

  acl_spi_arbiter #(.N_REQ(N), .GAP_CYCLES(GAP), .START_TIMEOUT(START), .DONE_TIMEOUT(4096)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_rd(req_rd), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_grant(req_grant), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .err_cnt(err_cnt),
    .spi_ready(spi_ready), .spi_inst(spi_inst), .spi_rdh_wrl(spi_rdh_wrl),
    .spi_reg_addr(spi_reg_addr), .spi_dout(spi_dout),
    .spi_csn(spi_csn), .spi_din(spi_din), .spi_din_valid(spi_din_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"}, 32'(req_grant), 0);
    check({tag, "_rsp"},   32'(rsp_valid), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_ecnt"},  32'(err_cnt), 0);
    check({tag, "_rdy"},   32'(spi_ready), 0);
    check({tag, "_inst"},  32'(spi_inst), 32'h0B);
    check({tag, "_rdh"},   32'(spi_rdh_wrl), 1);
    check({tag, "_addr"},  32'(spi_reg_addr), 0);
    check({tag, "_dout"},  32'(spi_dout), 0);
    check({tag, "_rdat"},  32'(rsp_rdata), 0);
    check({tag, "_rerr"},  32'(rsp_err), 0);
  endtask

  // Returns granted index (or -1) and number of negedges waited.
  task automatic wait_grant(output int idx, output int waited);
    idx = -1;
    waited = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      waited++;
      if (req_grant != '0) begin
        for (int i = 0; i < N; i++) if (req_grant[i]) idx = i;
        break;
      end
    end
    if (idx < 0) check("grant_timeout", 0, 1);
  endtask

  task automatic wait_rsp(output int waited);
    waited = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      waited++;
      if (rsp_valid != '0) return;
    end
    check("rsp_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!busy) return;
    end
    check("idle_timeout", 0, 1);
  endtask

  // Called at the grant negedge: CSN low for two cycles, optional byte, then CSN high.
  task automatic serve(input string tag, input logic with_data, input logic [7:0] dat,
                       input logic [N-1:0] exp_rsp);
    @(negedge clk) spi_csn = 1'b0;
    @(negedge clk) begin
      spi_din       = dat;
      spi_din_valid = with_data;
    end
    @(negedge clk) begin
      spi_din_valid = 1'b0;
      spi_csn       = 1'b1;
    end
    @(negedge clk);
    check({tag, "_rsp_vld"}, 32'(rsp_valid), 32'(exp_rsp));
  endtask

  task automatic set_req(input int i, input logic rd, input logic [7:0] a, input logic [7:0] d);
    req_rd[i]           = rd;
    req_addr[8*i +: 8]  = a;
    req_wdata[8*i +: 8] = d;
    req_valid[i]        = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog got=stuck exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, w;

    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;

    // Write from requester 0
    @(negedge clk) set_req(0, 1'b0, 8'h2D, 8'h0A);
    @(negedge clk);
    check("wr_grant", 32'(req_grant), 32'b001);
    check("wr_ready", 32'(spi_ready), 1);
    check("wr_inst",  32'(spi_inst), 32'h0A);
    check("wr_rdh",   32'(spi_rdh_wrl), 0);
    check("wr_addr",  32'(spi_reg_addr), 32'h2D);
    check("wr_dout",  32'(spi_dout), 32'h0A);
    check("wr_busy",  32'(busy), 1);
    req_valid[0] = 1'b0;
    serve("wr", 1'b0, 8'h00, 3'b001);
    check("wr_err",   32'(rsp_err), 0);
    check("wr_rdata", 32'(rsp_rdata), 0);
    repeat (GAP - 1) @(negedge clk);
    check("gap_last_busy", 32'(busy), 1);
    @(negedge clk);
    check("gap_end_idle", 32'(busy), 0);

    // Read from requester 1, byte 0x5A returned
    set_req(1, 1'b1, 8'h09, 8'hFF);
    wait_grant(idx, w);
    check("rd_idx",  32'(idx), 1);
    check("rd_lat",  32'(w), 1);
    check("rd_inst", 32'(spi_inst), 32'h0B);
    check("rd_rdh",  32'(spi_rdh_wrl), 1);
    check("rd_dout", 32'(spi_dout), 0);
    check("rd_addr", 32'(spi_reg_addr), 32'h09);
    req_valid[1] = 1'b0;
    serve("rd", 1'b1, 8'h5A, 3'b010);
    check("rd_rdata", 32'(rsp_rdata), 32'h5A);
    check("rd_err",   32'(rsp_err), 0);
    wait_idle();

    // Start timeout from requester 2: CSN never falls
    set_req(2, 1'b0, 8'h1F, 8'h52);
    wait_grant(idx, w);
    check("to_idx", 32'(idx), 2);
    req_valid[2] = 1'b0;
    wait_rsp(w);
    check("to_lat",  32'(w), START);
    check("to_rsp",  32'(rsp_valid), 32'b100);
    check("to_err",  32'(rsp_err), 1);
    check("to_ecnt", 32'(err_cnt), 1);
    wait_idle();

    // All three request continuously; last winner was 2
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'(8'h10 + i), 8'(8'h20 + i));
    for (int n = 0; n < 4; n++) begin
      int exp_i;
      exp_i = n % N;
      wait_grant(idx, w);
      check("arb_idx",  32'(idx), 32'(exp_i));
      check("arb_addr", 32'(spi_reg_addr), 32'(8'h10 + exp_i));
      check("arb_dout", 32'(spi_dout), 32'(8'h20 + exp_i));
      if (n > 0) check("arb_gap", 32'(w >= GAP + 1), 1);
      if (n == 3) req_valid = '0;
      serve("arb", 1'b0, 8'h00, N'(1) << exp_i);
    end
    wait_idle();

    // Stray byte outside WAIT_DONE, then a read that gets no byte
    @(negedge clk) begin
      spi_din       = 8'hEE;
      spi_din_valid = 1'b1;
    end
    @(negedge clk) spi_din_valid = 1'b0;
    set_req(1, 1'b1, 8'h0B, 8'h00);
    wait_grant(idx, w);
    check("nd_idx", 32'(idx), 1);
    req_valid[1] = 1'b0;
    serve("nd", 1'b0, 8'h00, 3'b010);
    check("nd_err",   32'(rsp_err), 1);
    check("nd_rdata", 32'(rsp_rdata), 0);
    check("nd_ecnt",  32'(err_cnt), 2);
    wait_idle();

    // Reset in WAIT_DONE with requester 0 still pending
    set_req(0, 1'b1, 8'h00, 8'h00);
    wait_grant(idx, w);
    check("rr_idx", 32'(idx), 0);
    @(negedge clk) spi_csn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst     = 1'b1;
    spi_csn = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    check("mid_rst_norsp", 32'(rsp_valid), 0);
    rst = 1'b0;
    wait_grant(idx, w);
    check("post_rst_idx", 32'(idx), 0);
    check("post_rst_ecnt", 32'(err_cnt), 0);
    req_valid[0] = 1'b0;
    serve("post_rst", 1'b1, 8'h33, 3'b001);
    check("post_rst_rdata", 32'(rsp_rdata), 32'h33);
    check("post_rst_err",   32'(rsp_err), 0);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
